rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Write-back scheduler for the 8-bit register file's single write port (we/ptr_w/di).
//   Merges ALU results and multi-cycle load returns into at most one RF write per cycle.
//   A small in-order queue buffers the requester that loses arbitration.
//   Flags read-after-write hazards on the RF read pointers so decode can stall.
// PARAMETERS
//   DW    = 8   data width; matches RF di/do_a/do_b
//   AW    = 5   register pointer width; matches ptr_w/ptr_a
//   NREG  = 9   RF entries; ptr 0 reads as zero, ptr NREG-1 is the hardware overflow reg
//   DEPTH = 4   pending-write queue depth; legal range 2..8
// PORTS
//   clk         in   1    clock
//   reset       in   1    synchronous, active-high reset
//   alu_valid   in   1    ALU write-back request
//   alu_ptr     in   AW   ALU destination register
//   alu_data    in   DW   ALU result
//   alu_ready   out  1    ALU request accepted this cycle when alu_valid & alu_ready
//   ld_valid    in   1    load-return write-back request
//   ld_ptr      in   AW   load destination register
//   ld_data     in   DW   load data
//   ld_ready    out  1    load request accepted this cycle when ld_valid & ld_ready
//   rd_ptr_a    in   AW   RF read pointer A (decode stage)
//   rd_ptr_b    in   AW   RF read pointer B; ignored when rd_b_const = 1
//   rd_b_const  in   1    operand B is an immediate, so no B hazard
//   hazard      out  1    a pending write targets rd_ptr_a or rd_ptr_b
//   rf_we       out  1    to RF we
//   rf_ptr_w    out  AW   to RF ptr_w
//   rf_di       out  DW   to RF di
//   q_count     out  4    valid queue entries, 0..DEPTH
//   wb_err      out  1    sticky flag: an illegal destination was dropped
// BEHAVIOUR
//   - Reset, synchronous: queue emptied; rf_we = 0, rf_ptr_w = 0, rf_di = 0, q_count = 0, wb_err = 0.
//     Pending writes are discarded and never reach the RF. Reset wins over a simultaneous valid.
//   - Readiness: alu_ready = ld_ready = (q_count <= DEPTH-2). Combinational from state only.
//   - Destination filter: an accepted request with ptr == 0 or ptr >= NREG-1 is dropped,
//     neither queued nor written, and sets wb_err on the next edge.
//   - Per-cycle order of accepted writes, oldest first: queue entries, then the load, then the ALU.
//   - Issue: the oldest write in that order is registered onto rf_we/rf_ptr_w/rf_di at the next edge.
//     The rest are enqueued in that order. Latency with an empty queue is 1 cycle from request to rf_we.
//     The RF is updated on the following edge.
//   - The queue never overflows: at most 2 enqueued and 1 dequeued per cycle, and readiness holds at q_count <= DEPTH-2.
//   - Same-destination collision in one cycle: the load is written first and the ALU value
//     second, so the ALU value is final. Writes to any one register are never reordered.
//   - rf_we = 0 in any cycle with nothing to issue; rf_ptr_w/rf_di then hold their last value.
//   - Pending set = the rf_we output stage + all queue entries + requests accepted this cycle.
//   - hazard = (rd_ptr_a != 0 && rd_ptr_a in pending set)
//     | (!rd_b_const && rd_ptr_b != 0 && rd_ptr_b in pending set). Combinational.
//   - Reads of register NREG-1 never raise hazard. The overflow register is written by hardware.
//   - Widths: q_count is zero-extended to 4 bits. ptr comparisons use the full AW bits.
// CONFIGURATION
//   RF_WB_BYPASS_EN defined: adds ports fwd_a_valid, fwd_b_valid (out, 1) and fwd_a_data, fwd_b_data (out, DW).
//     These carry the youngest pending value for the matching read pointer.
//     hazard is then forced to 0. Decode muxes the fwd data over do_a/do_b.
//   RF_WB_BYPASS_EN undefined: the fwd ports are absent. hazard behaves as in BEHAVIOUR.
// TESTING
//   1. Reset held 2 cycles with both valids = 1 -> rf_we = 0, q_count = 0, wb_err = 0, both readies = 1.
//   2. ALU only, ptr 3, data 0x5A, at cycle N -> rf_we = 1, ptr 3, di 0x5A at N+1; hazard = 1 for rd_ptr_a = 3 in N and N+1.
//   3. ALU (ptr 2, 0x11) and load (ptr 4, 0x22) in the same cycle -> load writes at N+1, ALU writes at N+2, q_count = 1 at N+1.
//   4. Both requesters target ptr 5 (load 0xAA, ALU 0xBB) -> writes 0xAA then 0xBB; the RF ends with 0xBB.
//   5. Both valid every cycle for 6 cycles -> readies drop when q_count = 3; no write is lost; 12 writes appear in order.
//   6. ALU writes to ptr 0 and to ptr 8 -> no rf_we for either, wb_err = 1 until reset.
//      With RF_WB_BYPASS_EN: case 2 gives fwd_a_valid = 1, fwd_a_data = 0x5A, hazard = 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: schedules ALU results and load returns onto the single
// register-file write port, at most one write per cycle. A small in-order
// queue buffers writes that lose arbitration. Read-after-write hazards on
// the decode read pointers are flagged so decode can stall.
// Optional feature macro: RF_WB_BYPASS_EN adds forwarding outputs carrying
// the youngest pending value for each read pointer and forces hazard low.
module rf_wb_arbiter #(
   parameter int DW    = 8,
   parameter int AW    = 5,
   parameter int NREG  = 9,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_ptr,
   input  logic [DW-1:0] alu_data,
   output logic          alu_ready,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_ptr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   input  logic [AW-1:0] rd_ptr_a,
   input  logic [AW-1:0] rd_ptr_b,
   input  logic          rd_b_const,
   output logic          hazard,
   output logic          rf_we,
   output logic [AW-1:0] rf_ptr_w,
   output logic [DW-1:0] rf_di,
   output logic [3:0]    q_count,
   output logic          wb_err
`ifdef RF_WB_BYPASS_EN
   ,
   output logic          fwd_a_valid,
   output logic          fwd_b_valid,
   output logic [DW-1:0] fwd_a_data,
   output logic [DW-1:0] fwd_b_data
`endif
);

   // Highest register index is the hardware overflow register; software
   // writes to it (or beyond) and to the zero register are dropped.
   localparam logic [AW-1:0] OVF_PTR = AW'(NREG - 1);
   // Accepting two new writes while issuing one grows the queue by at most
   // one, so accepting only up to DEPTH-2 entries keeps it from overflowing.
   localparam logic [3:0]    RDY_MAX = 4'(DEPTH - 2);

   typedef struct packed {
      logic [AW-1:0] ptr;
      logic [DW-1:0] data;
   } wb_entry_t;

   wb_entry_t q_mem     [DEPTH];
   wb_entry_t q_mem_nxt [DEPTH];
   logic [3:0] q_cnt;
   logic [3:0] q_cnt_nxt;

   logic      ready;
   logic      alu_acc, ld_acc;
   logic      alu_ok, ld_ok;
   logic      alu_bad, ld_bad;
   logic      issue_v;
   wb_entry_t issue_e;
   wb_entry_t alu_e, ld_e;

   function automatic logic legal_ptr(input logic [AW-1:0] p);
      return (p != '0) && (p < OVF_PTR);
   endfunction

   assign ready     = (q_cnt <= RDY_MAX);
   assign alu_ready = ready;
   assign ld_ready  = ready;
   assign q_count   = q_cnt;

   assign alu_acc = alu_valid & ready;
   assign ld_acc  = ld_valid & ready;
   assign alu_ok  = alu_acc & legal_ptr(alu_ptr);
   assign ld_ok   = ld_acc & legal_ptr(ld_ptr);
   assign alu_bad = alu_acc & ~legal_ptr(alu_ptr);
   assign ld_bad  = ld_acc & ~legal_ptr(ld_ptr);

   assign alu_e = '{ptr: alu_ptr, data: alu_data};
   assign ld_e  = '{ptr: ld_ptr, data: ld_data};

   // Pick the oldest write (queue head, then load, then ALU) for issue and
   // append the remaining accepted writes behind the queue in that order.
   always_comb begin
      int nq;
      q_mem_nxt = q_mem;
      issue_v   = 1'b0;
      issue_e   = '0;
      nq        = int'(q_cnt);
      if (q_cnt != 4'd0) begin
         issue_v = 1'b1;
         issue_e = q_mem[0];
         for (int i = 0; i < DEPTH - 1; i++) begin
            q_mem_nxt[i] = q_mem[i+1];
         end
         q_mem_nxt[DEPTH-1] = '0;
         nq = nq - 1;
      end
      if (ld_ok) begin
         if (!issue_v) begin
            issue_v = 1'b1;
            issue_e = ld_e;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (i == nq) q_mem_nxt[i] = ld_e;
            end
            nq = nq + 1;
         end
      end
      if (alu_ok) begin
         if (!issue_v) begin
            issue_v = 1'b1;
            issue_e = alu_e;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (i == nq) q_mem_nxt[i] = alu_e;
            end
            nq = nq + 1;
         end
      end
      q_cnt_nxt = 4'(nq);
   end

   // Queue storage and the registered RF write port; ptr/data hold when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
         q_cnt    <= 4'd0;
         rf_we    <= 1'b0;
         rf_ptr_w <= '0;
         rf_di    <= '0;
      end else begin
         q_mem <= q_mem_nxt;
         q_cnt <= q_cnt_nxt;
         rf_we <= issue_v;
         if (issue_v) begin
            rf_ptr_w <= issue_e.ptr;
            rf_di    <= issue_e.data;
         end
      end
   end

   // Sticky error flag for dropped illegal destinations.
   always_ff @(posedge clk) begin
      if (reset)                 wb_err <= 1'b0;
      else if (alu_bad | ld_bad) wb_err <= 1'b1;
   end

   logic hit_a, hit_b;
   logic chk_a, chk_b;
`ifdef RF_WB_BYPASS_EN
   logic [DW-1:0] yng_a, yng_b;
`endif

   assign chk_a = (rd_ptr_a != '0) && (rd_ptr_a != OVF_PTR);
   assign chk_b = !rd_b_const && (rd_ptr_b != '0) && (rd_ptr_b != OVF_PTR);

   // Match read pointers against the pending set, scanned oldest to youngest
   // so the last match is the value the RF will finally hold.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
`ifdef RF_WB_BYPASS_EN
      yng_a = '0;
      yng_b = '0;
`endif
      if (rf_we && rf_ptr_w == rd_ptr_a) begin
         hit_a = 1'b1;
`ifdef RF_WB_BYPASS_EN
         yng_a = rf_di;
`endif
      end
      if (rf_we && rf_ptr_w == rd_ptr_b) begin
         hit_b = 1'b1;
`ifdef RF_WB_BYPASS_EN
         yng_b = rf_di;
`endif
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (4'(i) < q_cnt) begin
            if (q_mem[i].ptr == rd_ptr_a) begin
               hit_a = 1'b1;
`ifdef RF_WB_BYPASS_EN
               yng_a = q_mem[i].data;
`endif
            end
            if (q_mem[i].ptr == rd_ptr_b) begin
               hit_b = 1'b1;
`ifdef RF_WB_BYPASS_EN
               yng_b = q_mem[i].data;
`endif
            end
         end
      end
      if (ld_ok && ld_ptr == rd_ptr_a) begin
         hit_a = 1'b1;
`ifdef RF_WB_BYPASS_EN
         yng_a = ld_data;
`endif
      end
      if (ld_ok && ld_ptr == rd_ptr_b) begin
         hit_b = 1'b1;
`ifdef RF_WB_BYPASS_EN
         yng_b = ld_data;
`endif
      end
      if (alu_ok && alu_ptr == rd_ptr_a) begin
         hit_a = 1'b1;
`ifdef RF_WB_BYPASS_EN
         yng_a = alu_data;
`endif
      end
      if (alu_ok && alu_ptr == rd_ptr_b) begin
         hit_b = 1'b1;
`ifdef RF_WB_BYPASS_EN
         yng_b = alu_data;
`endif
      end
   end

`ifdef RF_WB_BYPASS_EN
   assign fwd_a_valid = chk_a & hit_a;
   assign fwd_b_valid = chk_b & hit_b;
   assign fwd_a_data  = yng_a;
   assign fwd_b_data  = yng_b;
   assign hazard      = 1'b0;
`else
   assign hazard = (chk_a & hit_a) | (chk_b & hit_b);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed cases followed by random
// traffic, compared against a reference model of a single in-order write
// stream issued one entry per cycle.
module tb_rf_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int NREG  = 9;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       alu_valid = 1'b0, ld_valid = 1'b0, rd_b_const = 1'b0;
   logic [4:0] alu_ptr = '0, ld_ptr = '0, rd_ptr_a = '0, rd_ptr_b = '0;
   logic [7:0] alu_data = '0, ld_data = '0;
   logic       alu_ready, ld_ready, hazard, rf_we, wb_err;
   logic [4:0] rf_ptr_w;
   logic [7:0] rf_di;
   logic [3:0] q_count;

   rf_wb_arbiter #(.DW(8), .AW(5), .NREG(NREG), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ptr(alu_ptr), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_ptr(ld_ptr), .ld_data(ld_data), .ld_ready(ld_ready),
      .rd_ptr_a(rd_ptr_a), .rd_ptr_b(rd_ptr_b), .rd_b_const(rd_b_const), .hazard(hazard),
      .rf_we(rf_we), .rf_ptr_w(rf_ptr_w), .rf_di(rf_di), .q_count(q_count), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] p;
      logic [7:0] d;
   } ent_t;

   int   n_chk = 0;
   int   n_fail = 0;
   ent_t sb[$];   // expected RF writes, in order
   ent_t mq[$];   // model: writes waiting behind the output stage
   bit   m_out_v = 0;
   ent_t m_last = '{p: 5'd0, d: 8'd0};
   bit   m_err = 0;
   logic [7:0] dut_rf [32];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [4:0] p);
      return (p != 0) && (p < NREG - 1);
   endfunction

   // Monitor: every write the DUT presents must be the next expected one.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got ptr %0d data %0h expected none", rf_ptr_w, rf_di);
         end else begin
            ent_t e;
            e = sb.pop_front();
            chk("wr_ptr", 32'(rf_ptr_w), 32'(e.p));
            chk("wr_data", 32'(rf_di), 32'(e.d));
         end
         dut_rf[rf_ptr_w] = rf_di;
      end
   end

   task automatic step(input bit rst,
                       input bit av, input logic [4:0] ap, input logic [7:0] ad,
                       input bit lv, input logic [4:0] lp, input logic [7:0] ldd,
                       input logic [4:0] ra, input logic [4:0] rb, input bit bc,
                       output bit a_acc, output bit l_acc);
      bit   rdy, hz;
      ent_t pend[$];
      ent_t tmp[$];
      @(posedge clk);
      #1;
      reset = rst; alu_valid = av; alu_ptr = ap; alu_data = ad;
      ld_valid = lv; ld_ptr = lp; ld_data = ldd;
      rd_ptr_a = ra; rd_ptr_b = rb; rd_b_const = bc;
      @(negedge clk);
      rdy = (mq.size() <= DEPTH - 2);
      a_acc = av && rdy;
      l_acc = lv && rdy;
      chk("alu_ready", 32'(alu_ready), 32'(rdy));
      chk("ld_ready", 32'(ld_ready), 32'(rdy));
      chk("q_count", 32'(q_count), 32'(mq.size()));
      chk("rf_we", 32'(rf_we), 32'(m_out_v));
      chk("rf_ptr_w", 32'(rf_ptr_w), 32'(m_last.p));
      chk("rf_di", 32'(rf_di), 32'(m_last.d));
      chk("wb_err", 32'(wb_err), 32'(m_err));
      if (m_out_v) pend.push_back(m_last);
      foreach (mq[i]) pend.push_back(mq[i]);
      if (l_acc && legal(lp)) pend.push_back('{p: lp, d: ldd});
      if (a_acc && legal(ap)) pend.push_back('{p: ap, d: ad});
      hz = 0;
      foreach (pend[i]) begin
         if (ra != 0 && pend[i].p == ra) hz = 1;
         if (!bc && rb != 0 && pend[i].p == rb) hz = 1;
      end
      chk("hazard", 32'(hazard), 32'(hz));
      #1;
      if (rst) begin
         mq.delete();
         m_out_v = 0;
         m_last = '{p: 5'd0, d: 8'd0};
         m_err = 0;
      end else begin
         tmp = mq;
         if (l_acc) begin
            if (legal(lp)) tmp.push_back('{p: lp, d: ldd});
            else m_err = 1;
         end
         if (a_acc) begin
            if (legal(ap)) tmp.push_back('{p: ap, d: ad});
            else m_err = 1;
         end
         if (tmp.size() > 0) begin
            m_last = tmp.pop_front();
            m_out_v = 1;
            sb.push_back(m_last);
         end else begin
            m_out_v = 0;
         end
         mq = tmp;
      end
   endtask

   task automatic idle(input int n, input logic [4:0] ra);
      bit a, l;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ra, 0, 1, a, l);
   endtask

   initial begin
      bit a, l;
      int ia, il, guard;
      foreach (dut_rf[i]) dut_rf[i] = 8'h00;

      // Reset held with both requesters asking.
      step(1, 1, 5'd3, 8'h01, 1, 5'd4, 8'h02, 5'd3, 5'd0, 1, a, l);
      step(1, 1, 5'd3, 8'h01, 1, 5'd4, 8'h02, 5'd3, 5'd0, 1, a, l);
      idle(1, 5'd3);

      // Single ALU write with a read of the same register.
      step(0, 1, 5'd3, 8'h5A, 0, 0, 0, 5'd3, 5'd0, 1, a, l);
      idle(3, 5'd3);
      chk("rf3", 32'(dut_rf[3]), 32'h5A);

      // ALU and load together: load first, ALU one cycle later.
      step(0, 1, 5'd2, 8'h11, 1, 5'd4, 8'h22, 5'd2, 5'd4, 0, a, l);
      idle(3, 5'd0);

      // Same-destination collision: ALU value is final.
      step(0, 1, 5'd5, 8'hBB, 1, 5'd5, 8'hAA, 5'd5, 5'd0, 1, a, l);
      idle(3, 5'd5);
      chk("rf5_final", 32'(dut_rf[5]), 32'hBB);

      // Both requesters saturated; requests held until accepted.
      ia = 0; il = 0; guard = 0;
      while ((ia < 6 || il < 6) && guard < 40) begin
         step(0, ia < 6, 5'(1 + ia), 8'(8'h30 + ia), il < 6, 5'(7 - il), 8'(8'h60 + il),
              5'(1 + ia), 5'(7 - il), 0, a, l);
         if (a && ia < 6) ia++;
         if (l && il < 6) il++;
         guard++;
      end
      chk("saturate_done", 32'(ia + il), 32'd12);
      idle(8, 5'd0);

      // Illegal destinations are dropped and flagged.
      step(0, 1, 5'd0, 8'hC1, 0, 0, 0, 5'd0, 5'd0, 1, a, l);
      step(0, 1, 5'd8, 8'hC2, 0, 0, 0, 5'd8, 5'd8, 0, a, l);
      idle(3, 5'd0);
      chk("wb_err_sticky", 32'(wb_err), 32'd1);

      // Random traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 2) != 0, 5'($urandom_range(0, 10)), 8'($urandom),
              $urandom_range(0, 2) != 0, 5'($urandom_range(0, 10)), 8'($urandom),
              5'($urandom_range(0, 10)), 5'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
              a, l);
      end

      guard = 0;
      while ((mq.size() > 0 || m_out_v) && guard < 20) begin
         idle(1, 5'd0);
         guard++;
      end
      idle(2, 5'd0);
      chk("drain_bound", 32'(guard < 20), 32'd1);
      chk("writes_outstanding", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
